// File: rtl/udp_tx_arbiter_if.sv
// Bundles the per-source UDP header/payload channels and the shared transmit channel.
// 'master' is the arbiter's view, 'slave' the view of the sources and the stack.
interface udp_tx_arbiter_if #(
  parameter int unsigned N_SRC = 2
);
  logic [N_SRC-1:0]    src_hdr_valid;
  logic [N_SRC-1:0]    src_hdr_ready;
  logic [16*N_SRC-1:0] src_dest_port;
  logic [16*N_SRC-1:0] src_length;
  logic [8*N_SRC-1:0]  src_tdata;
  logic [N_SRC-1:0]    src_tvalid;
  logic [N_SRC-1:0]    src_tlast;
  logic [N_SRC-1:0]    src_tuser;
  logic [N_SRC-1:0]    src_tready;

  logic                tx_udp_hdr_valid;
  logic                tx_udp_hdr_ready;
  logic [15:0]         tx_udp_dest_port;
  logic [15:0]         tx_udp_length;
  logic [7:0]          tx_udp_payload_tdata;
  logic                tx_udp_payload_tvalid;
  logic                tx_udp_payload_tlast;
  logic                tx_udp_payload_tuser;
  logic                tx_udp_payload_tready;

  modport master (
    input  src_hdr_valid, src_dest_port, src_length,
    input  src_tdata, src_tvalid, src_tlast, src_tuser,
    output src_hdr_ready, src_tready,
    output tx_udp_hdr_valid, tx_udp_dest_port, tx_udp_length,
    output tx_udp_payload_tdata, tx_udp_payload_tvalid, tx_udp_payload_tlast,
    output tx_udp_payload_tuser,
    input  tx_udp_hdr_ready, tx_udp_payload_tready
  );

  modport slave (
    output src_hdr_valid, src_dest_port, src_length,
    output src_tdata, src_tvalid, src_tlast, src_tuser,
    input  src_hdr_ready, src_tready,
    input  tx_udp_hdr_valid, tx_udp_dest_port, tx_udp_length,
    input  tx_udp_payload_tdata, tx_udp_payload_tvalid, tx_udp_payload_tlast,
    input  tx_udp_payload_tuser,
    output tx_udp_hdr_ready, tx_udp_payload_tready
  );
endinterface

// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter sharing one UDP transmit path between N_SRC sources.
// A grant is taken on a header request and held until the tlast payload beat completes.
module udp_tx_arbiter #(
  parameter int unsigned N_SRC = 2,
  parameter int unsigned IDX_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  udp_tx_arbiter_if.master bus,
  output logic             grant_active,
  output logic [IDX_W-1:0] grant_idx,
  output logic [15:0]      frame_count
);

  typedef enum logic [1:0] {StIdle, StHdr, StPayload} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic               grant_active_q, grant_active_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic [IDX_W-1:0]   winner;
  logic [N_SRC-1:0]   req_rot;
  logic [N_SRC-1:0]   gnt_oh;
  logic               sel_hdr_valid, sel_tvalid, sel_tlast;

  // Rotate requests so rr_ptr lands on bit 0; the lowest set bit is the winner's offset.
  always_comb begin
    int unsigned sum;
    req_rot = N_SRC'({bus.src_hdr_valid, bus.src_hdr_valid} >> rr_ptr_q);
    sum = 32'(rr_ptr_q);
    for (int k = int'(N_SRC) - 1; k >= 0; k--) begin
      if (req_rot[k]) sum = 32'(rr_ptr_q) + 32'(k);
    end
    if (sum >= N_SRC) sum = sum - N_SRC;
    winner = IDX_W'(sum);
  end

  assign gnt_oh = N_SRC'(1) << grant_idx_q;

  always_comb begin
    bus.tx_udp_dest_port     = '0;
    bus.tx_udp_length        = '0;
    bus.tx_udp_payload_tdata = '0;
    bus.tx_udp_payload_tuser = 1'b0;
    sel_hdr_valid            = 1'b0;
    sel_tvalid               = 1'b0;
    sel_tlast                = 1'b0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (gnt_oh[i]) begin
        bus.tx_udp_dest_port     = bus.src_dest_port[16*i +: 16];
        bus.tx_udp_length        = bus.src_length[16*i +: 16];
        bus.tx_udp_payload_tdata = bus.src_tdata[8*i +: 8];
        bus.tx_udp_payload_tuser = bus.src_tuser[i];
        sel_hdr_valid            = bus.src_hdr_valid[i];
        sel_tvalid               = bus.src_tvalid[i];
        sel_tlast                = bus.src_tlast[i];
      end
    end
  end

  assign bus.tx_udp_payload_tlast = sel_tlast;

  always_comb begin
    int unsigned nxt;
    state_d               = state_q;
    rr_ptr_d              = rr_ptr_q;
    grant_idx_d           = grant_idx_q;
    grant_active_d        = grant_active_q;
    frame_count_d         = frame_count_q;
    bus.tx_udp_hdr_valid      = 1'b0;
    bus.tx_udp_payload_tvalid = 1'b0;
    bus.src_hdr_ready         = '0;
    bus.src_tready            = '0;
    nxt = 32'(grant_idx_q) + 1;
    if (nxt >= N_SRC) nxt = 0;

    case (state_q)
      StIdle: begin
        if (|bus.src_hdr_valid) begin
          state_d        = StHdr;
          grant_idx_d    = winner;
          grant_active_d = 1'b1;
        end
      end
      StHdr: begin
        bus.tx_udp_hdr_valid = sel_hdr_valid;
        bus.src_hdr_ready    = gnt_oh & {N_SRC{bus.tx_udp_hdr_ready}};
        if (sel_hdr_valid && bus.tx_udp_hdr_ready) state_d = StPayload;
      end
      StPayload: begin
        bus.tx_udp_payload_tvalid = sel_tvalid;
        bus.src_tready            = gnt_oh & {N_SRC{bus.tx_udp_payload_tready}};
        if (sel_tvalid && bus.tx_udp_payload_tready && sel_tlast) begin
          state_d        = StIdle;
          rr_ptr_d       = IDX_W'(nxt);
          frame_count_d  = frame_count_q + 16'd1;
          grant_active_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      rr_ptr_q       <= '0;
      grant_idx_q    <= '0;
      grant_active_q <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_idx_q    <= grant_idx_d;
      grant_active_q <= grant_active_d;
      frame_count_q  <= frame_count_d;
    end
  end

  assign grant_active = grant_active_q;
  assign grant_idx    = grant_idx_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Scoreboard bench for udp_tx_arbiter: tests push expected header/payload events, a monitor
// pops and compares them on every transmit-side handshake.
module tb_udp_tx_arbiter;
  localparam int unsigned NSrc = 2;
  localparam int unsigned IdxW = 3;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            grant_active;
  logic [IdxW-1:0] grant_idx;
  logic [15:0]     frame_count;

  udp_tx_arbiter_if #(.N_SRC(NSrc)) bus ();

  udp_tx_arbiter #(.N_SRC(NSrc), .IDX_W(IdxW)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .grant_active (grant_active),
    .grant_idx    (grant_idx),
    .frame_count  (frame_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] port;
    logic [15:0] len;
    logic [7:0]  n;
    logic [7:0]  base;
    logic        user;
  } frame_t;

  typedef struct packed {
    logic        is_hdr;
    logic [2:0]  src;
    logic [15:0] a;
    logic [15:0] b;
    logic        last;
    logic        user;
  } exp_t;

  frame_t fq0[$];
  frame_t fq1[$];
  exp_t   exp_q[$];
  int     n_cmp = 0;
  int     n_fail = 0;
  int     st   [NSrc];
  int     beat [NSrc];
  frame_t cur  [NSrc];
  bit     hs   [NSrc];
  bit     bp = 1'b0;
  int     cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // Queue a frame on source s and push the events the stack side should see for it.
  task automatic send(input int s, input logic [15:0] port, input logic [15:0] len,
                      input int n, input logic [7:0] base, input logic user);
    frame_t f;
    exp_t   e;
    f = '{port: port, len: len, n: 8'(n), base: base, user: user};
    if (s == 0) fq0.push_back(f);
    else fq1.push_back(f);
    e = '{is_hdr: 1'b1, src: 3'(s), a: port, b: len, last: 1'b0, user: 1'b0};
    exp_q.push_back(e);
    for (int k = 0; k < n; k++) begin
      e = '{is_hdr: 1'b0, src: 3'(s), a: {8'h00, base + 8'(k)}, b: 16'h0,
            last: (k == n - 1), user: user && (k == n - 1)};
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_src(input int s);
    logic       hv, tv, tl;
    logic [7:0] d;
    hv = (st[s] == 1);
    tv = (st[s] == 2);
    d  = cur[s].base + 8'(beat[s]);
    tl = tv && (beat[s] == int'(cur[s].n) - 1);
    bus.src_hdr_valid[s]         = hv;
    bus.src_dest_port[16*s +: 16] = hv ? cur[s].port : 16'h0;
    bus.src_length[16*s +: 16]    = hv ? cur[s].len : 16'h0;
    bus.src_tvalid[s]            = tv;
    bus.src_tdata[8*s +: 8]      = tv ? d : 8'h0;
    bus.src_tlast[s]             = tl;
    bus.src_tuser[s]             = tl && cur[s].user;
  endtask

  // Source and stack driver: advances each source on the handshake predicted last cycle.
  initial begin : driver
    bus.src_hdr_valid = '0;
    bus.src_dest_port = '0;
    bus.src_length    = '0;
    bus.src_tdata     = '0;
    bus.src_tvalid    = '0;
    bus.src_tlast     = '0;
    bus.src_tuser     = '0;
    bus.tx_udp_hdr_ready      = 1'b1;
    bus.tx_udp_payload_tready = 1'b1;
    for (int s = 0; s < int'(NSrc); s++) begin
      st[s] = 0;
      beat[s] = 0;
      hs[s] = 1'b0;
    end
    forever begin
      @(negedge clock);
      cyc++;
      for (int s = 0; s < int'(NSrc); s++) begin
        if (!reset) begin
          st[s] = 0;
          hs[s] = 1'b0;
        end else begin
          if (st[s] == 1 && hs[s]) begin
            st[s] = 2;
            beat[s] = 0;
          end else if (st[s] == 2 && hs[s]) begin
            beat[s]++;
            if (beat[s] == int'(cur[s].n)) st[s] = 0;
          end
          if (st[s] == 0) begin
            if (s == 0 && fq0.size() > 0) begin
              cur[s] = fq0.pop_front();
              st[s] = 1;
            end else if (s == 1 && fq1.size() > 0) begin
              cur[s] = fq1.pop_front();
              st[s] = 1;
            end
          end
        end
        drive_src(s);
      end
      bus.tx_udp_payload_tready = bp ? cyc[0] : 1'b1;
      #1;
      for (int s = 0; s < int'(NSrc); s++) begin
        hs[s] = (st[s] == 1) ? bus.src_hdr_ready[s] :
                (st[s] == 2) ? bus.src_tready[s] : 1'b0;
      end
    end
  end

  initial begin : monitor
    exp_t            e;
    logic [NSrc-1:0] mask;
    forever begin
      @(negedge clock);
      #2;
      mask = NSrc'(1) << grant_idx;
      check("hdr_ready_ungranted", 32'(bus.src_hdr_ready & ~mask), 32'h0);
      check("tready_ungranted", 32'(bus.src_tready & ~mask), 32'h0);
      if (bus.tx_udp_hdr_valid && bus.tx_udp_hdr_ready) begin
        check("hdr_expected", 32'(exp_q.size() > 0), 32'h1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("hdr_kind", 32'(e.is_hdr), 32'h1);
          check("hdr_port", 32'(bus.tx_udp_dest_port), 32'(e.a));
          check("hdr_len", 32'(bus.tx_udp_length), 32'(e.b));
          check("hdr_grant", 32'(grant_idx), 32'(e.src));
        end
      end
      if (bus.tx_udp_payload_tvalid && bus.tx_udp_payload_tready) begin
        check("beat_expected", 32'(exp_q.size() > 0), 32'h1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("beat_kind", 32'(e.is_hdr), 32'h0);
          check("beat_data", 32'(bus.tx_udp_payload_tdata), 32'(e.a));
          check("beat_last", 32'(bus.tx_udp_payload_tlast), 32'(e.last));
          check("beat_user", 32'(bus.tx_udp_payload_tuser), 32'(e.user));
          check("beat_grant", 32'(grant_idx), 32'(e.src));
        end
      end
    end
  end

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clock);
      #3;
      done = exp_q.size() == 0 && fq0.size() == 0 && fq1.size() == 0 &&
             st[0] == 0 && st[1] == 0;
    end
    check({name, "_drain"}, 32'(done), 32'h1);
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_hdr_valid"}, 32'(bus.tx_udp_hdr_valid), 32'h0);
    check({name, "_tvalid"}, 32'(bus.tx_udp_payload_tvalid), 32'h0);
    check({name, "_hdr_ready"}, 32'(bus.src_hdr_ready), 32'h0);
    check({name, "_tready"}, 32'(bus.src_tready), 32'h0);
    check({name, "_grant_active"}, 32'(grant_active), 32'h0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got still running, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit found;
    repeat (2) @(negedge clock);
    #1;
    check_quiet("reset");
    check("reset_grant_idx", 32'(grant_idx), 32'h0);
    check("reset_frame_count", 32'(frame_count), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #3;
    check_quiet("post_release");

    // Both sources request continuously: frames alternate starting with src0.
    send(0, 16'd1000, 16'd10, 3, 8'h10, 1'b0);
    send(1, 16'd2000, 16'd11, 2, 8'h20, 1'b0);
    send(0, 16'd1001, 16'd12, 1, 8'h30, 1'b0);
    send(1, 16'd2001, 16'd13, 4, 8'h40, 1'b0);
    send(0, 16'd1002, 16'd14, 2, 8'h50, 1'b0);
    send(1, 16'd2002, 16'd15, 3, 8'h60, 1'b0);
    wait_drain("contention");
    check("contention_count", 32'(frame_count), 32'd6);
    check("contention_grant_idx", 32'(grant_idx), 32'd1);

    // Single source: header visible one cycle after the request is raised.
    @(negedge clock);
    #3;
    send(0, 16'd1234, 16'd12, 4, 8'hA0, 1'b0);
    @(negedge clock);
    #1;
    check("latency_same_cycle", 32'(bus.tx_udp_hdr_valid), 32'h0);
    @(negedge clock);
    #1;
    check("latency_hdr_valid", 32'(bus.tx_udp_hdr_valid), 32'h1);
    check("latency_port", 32'(bus.tx_udp_dest_port), 32'd1234);
    check("latency_len", 32'(bus.tx_udp_length), 32'd12);
    wait_drain("single");
    check("single_count", 32'(frame_count), 32'd7);
    check("single_grant_idx", 32'(grant_idx), 32'd0);

    // Backpressure with src1 raising its request in the middle of src0's frame.
    bp = 1'b1;
    send(0, 16'd3000, 16'd20, 5, 8'hC0, 1'b0);
    repeat (3) @(negedge clock);
    #3;
    check("bp_grant_active", 32'(grant_active), 32'h1);
    check("bp_grant_idx", 32'(grant_idx), 32'd0);
    send(1, 16'd3001, 16'd21, 2, 8'hD0, 1'b0);
    wait_drain("backpressure");
    bp = 1'b0;
    check("bp_count", 32'(frame_count), 32'd9);

    // Reset during beat 2 of 5; rr_ptr would point at src1 had the reset not cleared it.
    send(0, 16'd4000, 16'd30, 2, 8'h70, 1'b0);
    wait_drain("pre_reset");
    check("pre_reset_count", 32'(frame_count), 32'd10);
    send(0, 16'd4001, 16'd31, 5, 8'h80, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clock);
      #3;
      found = (st[0] == 2 && beat[0] == 1);
    end
    check("reach_beat2", 32'(found), 32'h1);
    check("midframe_tready", 32'(bus.src_tready), 32'h1);
    reset = 1'b0;
    #1;
    check_quiet("midreset");
    check("midreset_grant_idx", 32'(grant_idx), 32'h0);
    check("midreset_frame_count", 32'(frame_count), 32'h0);
    exp_q.delete();
    repeat (2) @(negedge clock);
    #3;
    reset = 1'b1;
    @(negedge clock);
    #3;
    check_quiet("after_reset");
    check("after_reset_count", 32'(frame_count), 32'h0);
    send(1, 16'd5000, 16'd40, 3, 8'hE0, 1'b0);
    wait_drain("after_reset");
    check("after_reset_grant_idx", 32'(grant_idx), 32'd1);
    check("after_reset_frame", 32'(frame_count), 32'd1);

    // Counter wrap on a single-beat frame with tuser set on its only beat.
    @(negedge clock);
    force dut.frame_count_q = 16'hFFFF;
    @(negedge clock);
    release dut.frame_count_q;
    #3;
    check("preload_count", 32'(frame_count), 32'hFFFF);
    send(0, 16'd6000, 16'd9, 1, 8'hF0, 1'b1);
    wait_drain("wrap");
    check("wrap_count", 32'(frame_count), 32'h0);
    send(1, 16'd6001, 16'd10, 3, 8'h05, 1'b1);
    wait_drain("tuser");
    check("tuser_count", 32'(frame_count), 32'h1);
    check("tuser_grant_idx", 32'(grant_idx), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/udp_tx_arbiter.md
# udp_tx_arbiter

Round-robin arbiter that shares the single UDP transmit path (header channel plus 8-bit AXI-stream payload) between `N_SRC` requesters, e.g. the port-1234 loopback and a register-readback source. A grant is taken on a header request and held until the payload beat carrying `tlast` completes, so frames never interleave. It sits between the UDP sources and the UDP/IP transmit stack.

## Interface

Parameters:
- `N_SRC`, 2: number of requesters, 2..8.
- `IDX_W`, 3: width of the grant index; must satisfy 2^IDX_W >= N_SRC.

Ports (vector slice i belongs to source i):
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `src_hdr_valid`  in  N_SRC  header request per source.
- `src_hdr_ready`  out  N_SRC  header accepted.
- `src_dest_port`  in  16*N_SRC  UDP destination port.
- `src_length`  in  16*N_SRC  UDP length field.
- `src_tdata`  in  8*N_SRC  payload byte.
- `src_tvalid`, `src_tlast`, `src_tuser`  in  N_SRC  payload qualifiers.
- `src_tready`  out  N_SRC  payload ready.
- `tx_udp_hdr_valid`  out  1  header to stack.
- `tx_udp_hdr_ready`  in  1  stack accepts header.
- `tx_udp_dest_port`, `tx_udp_length`  out  16  muxed header fields.
- `tx_udp_payload_tdata`  out  8  muxed payload.
- `tx_udp_payload_tvalid`, `tx_udp_payload_tlast`, `tx_udp_payload_tuser`  out  1  muxed qualifiers.
- `tx_udp_payload_tready`  in  1  stack ready.
- `grant_active`  out  1  a frame is in progress.
- `grant_idx`  out  IDX_W  current or last granted source.
- `frame_count`  out  16  completed frames; wraps 0xFFFF to 0.

## Operation

- State machine states:
  - IDLE: no grant; all src ready outputs low; tx valids low.
  - HDR: header channel connected to `grant_idx`.
  - PAYLOAD: payload channel connected to `grant_idx`.
- IDLE to HDR:
  - Triggered when any `src_hdr_valid` is high.
  - Winner is the first requesting index at or after `rr_ptr`, searching upward modulo N_SRC.
  - `grant_idx` is registered with the winner and `grant_active` is set.
- HDR:
  - `tx_udp_hdr_valid = src_hdr_valid[g]`.
  - `src_hdr_ready[g] = tx_udp_hdr_ready`; all other slices of `src_hdr_ready` are 0.
  - `tx_udp_dest_port` and `tx_udp_length` are driven combinationally from slice g.
  - Moves to PAYLOAD on a header handshake.
- PAYLOAD:
  - Payload outputs come from slice g; `src_tready[g] = tx_udp_payload_tready`; other `src_tready` slices are 0.
  - On a handshake with `tlast`=1, the block returns to IDLE, sets `rr_ptr = (g+1) mod N_SRC`, increments `frame_count` and clears `grant_active`.
  - The `tuser` (error) flag is forwarded only; the frame still counts.
- Outside HDR, `tx_udp_hdr_valid`=0. Outside PAYLOAD, `tx_udp_payload_tvalid`=0.
- Requests arriving during a grant wait. Winner selection happens only in IDLE.
- Sources must hold header fields stable while `hdr_valid` is high (AXI rule). The arbiter does not buffer headers.
- Reset (asynchronous, anywhere including mid-frame):
  - State goes to IDLE; `rr_ptr`=0, `grant_idx`=0, `grant_active`=0, `frame_count`=0.
  - All ready and valid outputs are 0.
  - A frame cut by reset is abandoned; the stack is responsible for recovery.

## Timing

- Arbitration latency: request seen in IDLE at edge k, `tx_udp_hdr_valid` high after edge k+1. That is 1 cycle.
- Header and payload paths are combinational pass-through once granted; they add 0 cycles of latency and insert no bubbles between payload beats.
- Turnaround: the `tlast` handshake at edge k gives IDLE after edge k; the next header is presented after edge k+1. This is 1 idle cycle between frames.
- A single-beat frame (first beat carries `tlast`) takes HDR 1 cycle plus PAYLOAD 1 cycle minimum.
- Reset release is taken at the next rising edge. All outputs stay at reset values until a request arrives.

## Test plan

- Single source: src0 sends a 4-byte frame to port 1234 with length 12, stack always ready.
  - Output header is 1234/12 exactly 1 cycle after request.
  - Bytes pass unmodified; `frame_count`=1 and `grant_idx`=0.
- Contention: src0 and src1 both request continuously, 3 frames each, `N_SRC`=2.
  - Output frame order is 0,1,0,1,0,1.
  - No byte from one source appears inside another source's frame.
- Backpressure: `tx_udp_payload_tready` toggles every cycle mid-frame.
  - Ungranted `src_tready` stays 0; payload order is preserved.
  - Grant is held until `tlast`.
  - A request from src1 raised mid-frame is served only after src0's `tlast`.
- Reset mid-frame: assert reset during beat 2 of 5.
  - All valid and ready outputs go 0 immediately.
  - After release, a src1 request wins because `rr_ptr`=0 and src0 is idle.
  - `frame_count`=0 after release.
- Wrap: preload 65535 frames (or force the counter).
  - The next completed frame gives `frame_count`=0.
- `tuser`=1 on the last beat: the flag appears on `tx_udp_payload_tuser` and the frame is counted.
